// File: rtl/oram_pkg.sv
// oram_pkg -- shared constants, storage types and FSM encoding for the
// Path-ORAM controller.
//   A   : bytes per block (data width DW = 8*A)
//   D   : logical address width (2^D blocks, 2^D leaves, D+1 tree levels)
//   Z   : slots per bucket
//   S   : stash entries
// Optional feature macro used by the controller: ORAM_REMAP_EN.
package oram_pkg;

  localparam int A  = 4;
  localparam int D  = 3;
  localparam int Z  = 2;
  localparam int S  = Z * (D + 1) + 8;

  localparam int DW = 8 * A;
  localparam int NL = 1 << D;              // leaves == blocks
  localparam int NB = (1 << (D + 1)) - 1;  // buckets in the tree
  localparam int BW = $clog2(NB);          // bucket index width
  localparam int LW = $clog2(D + 1);       // level counter width
  localparam int SW = $clog2(S);           // stash index width

  // One tree slot or stash entry.
  typedef struct packed {
    logic          valid;
    logic [D-1:0]  addr;
    logic [D-1:0]  leaf;
    logic [DW-1:0] data;
  } slot_t;

  typedef enum logic [2:0] {
    IDLE,
    READ_PATH,
    UPDATE,
    WRITE_PATH,
    DONE
  } state_t;

  // Heap-ordered bucket index of the node at level lvl on the path to leaf.
  function automatic logic [BW-1:0] bucket_idx(input logic [D-1:0] leaf,
                                               input int unsigned lvl);
    int unsigned idx;
    idx = ((32'd1 << lvl) - 32'd1) + (32'(leaf) >> (D - lvl));
    return BW'(idx);
  endfunction

endpackage

// File: rtl/oram_lfsr.sv
// oram_lfsr -- 16-bit maximal Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that
// supplies fresh leaves for block remapping.
//   clk    : rising-edge clock
//   rst    : async active-low reset, loads seed_i
//   en_i   : advance one step per clock when high
//   seed_i : reset value (must be non-zero)
//   leaf_o : low D bits of the current state
module oram_lfsr
  import oram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [15:0]   seed_i,
  output logic [D-1:0]  leaf_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= seed_i;
    else      lfsr_q <= lfsr_d;
  end

  assign leaf_o = lfsr_q[D-1:0];

endmodule

// File: rtl/oram.sv
// oram -- Path-ORAM controller. Every access reads one root-to-leaf path into
// the stash, serves the request from the stash, then writes the same path
// back, so the physical access pattern is independent of the logical address.
//   clk          : rising-edge clock
//   rst          : async active-low reset, clears all stored contents
//   block_num    : logical block address (sampled at accept)
//   write_val    : write data (sampled at accept)
//   rw_indicator : 1 = write, 0 = read (sampled at accept)
//   input_ready  : request valid, level-sensitive
//   read_val     : block contents before the access, updated at UPDATE
//   output_ready : one-cycle completion pulse
// Macro ORAM_REMAP_EN: remap each accessed block to an LFSR-chosen leaf.
// Without it the position map is the identity and no LFSR is built.
module oram
  import oram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [D-1:0]  block_num,
  input  logic [DW-1:0] write_val,
  input  logic          rw_indicator,
  input  logic          input_ready,
  output logic [DW-1:0] read_val,
  output logic          output_ready
);

  state_t        state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [D-1:0]  addr_q, addr_d;
  logic [D-1:0]  leaf_q, leaf_d;     // path x being accessed
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] read_val_q, read_val_d;
  logic          output_ready_q;

  slot_t         tree_q  [NB][Z];
  slot_t         tree_d  [NB][Z];
  slot_t         stash_q [S];
  slot_t         stash_d [S];

  logic [D-1:0]  lookup_leaf;
  logic [D-1:0]  new_leaf;
  logic [BW-1:0] bkt;
  logic          placed;
  logic          hit;
  logic [SW-1:0] hit_idx;
  int unsigned   shamt;

`ifdef ORAM_REMAP_EN
  logic [D-1:0]  posmap_q [NL];
  logic [D-1:0]  posmap_d [NL];
  logic [D-1:0]  lfsr_leaf;

  oram_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .seed_i (16'h0001),
    .leaf_o (lfsr_leaf)
  );

  assign lookup_leaf = posmap_q[block_num];
  assign new_leaf    = lfsr_leaf;
`else
  assign lookup_leaf = block_num;
  assign new_leaf    = addr_q;
`endif

  assign bkt   = bucket_idx(leaf_q, 32'(lvl_q));
  assign shamt = D - 32'(lvl_q);

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    addr_d     = addr_q;
    leaf_d     = leaf_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    read_val_d = read_val_q;
    tree_d     = tree_q;
    stash_d    = stash_q;
    placed     = 1'b0;
    hit        = 1'b0;
    hit_idx    = '0;
`ifdef ORAM_REMAP_EN
    posmap_d   = posmap_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (input_ready) begin
          addr_d  = block_num;
          wdata_d = write_val;
          rw_d    = rw_indicator;
          leaf_d  = lookup_leaf;
          lvl_d   = '0;
          state_d = READ_PATH;
        end
      end

      READ_PATH: begin
        // Move each valid slot into the first free stash entry; a slot with
        // no room left simply stays in the tree.
        for (int z = 0; z < Z; z++) begin
          if (tree_q[bkt][z].valid) begin
            placed = 1'b0;
            for (int s = 0; s < S; s++) begin
              if (!placed && !stash_d[s].valid) begin
                stash_d[s]          = tree_q[bkt][z];
                tree_d[bkt][z].valid = 1'b0;
                placed              = 1'b1;
              end
            end
          end
        end
        if (lvl_q == LW'(D)) state_d = UPDATE;
        else                 lvl_d   = lvl_q + 1'b1;
      end

      UPDATE: begin
        for (int s = 0; s < S; s++) begin
          if (!hit && stash_q[s].valid && stash_q[s].addr == addr_q) begin
            hit     = 1'b1;
            hit_idx = SW'(s);
          end
        end
        read_val_d = hit ? stash_q[hit_idx].data : '0;
        if (hit) begin
          stash_d[hit_idx].leaf = new_leaf;
          if (rw_q) stash_d[hit_idx].data = wdata_q;
        end else if (rw_q) begin
          // A read miss allocates nothing; only a write creates the block.
          for (int s = 0; s < S; s++) begin
            if (!placed && !stash_q[s].valid) begin
              stash_d[s] = '{valid: 1'b1, addr: addr_q, leaf: new_leaf, data: wdata_q};
              placed     = 1'b1;
            end
          end
        end
`ifdef ORAM_REMAP_EN
        posmap_d[addr_q] = new_leaf;
`endif
        lvl_d   = LW'(D);
        state_d = WRITE_PATH;
      end

      WRITE_PATH: begin
        // A block may live in this bucket only if its leaf path passes
        // through it, i.e. its top lvl leaf bits match those of x.
        for (int z = 0; z < Z; z++) begin
          if (!tree_q[bkt][z].valid) begin
            placed = 1'b0;
            for (int s = 0; s < S; s++) begin
              if (!placed && stash_d[s].valid &&
                  ((stash_d[s].leaf >> shamt) == (leaf_q >> shamt))) begin
                tree_d[bkt][z]   = stash_d[s];
                stash_d[s].valid = 1'b0;
                placed           = 1'b1;
              end
            end
          end
        end
        if (lvl_q == '0) state_d = DONE;
        else             lvl_d   = lvl_q - 1'b1;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: tree and stash are reset in full because their valid bits define
  // what is stored; clearing the payload with them keeps the reset uniform.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      lvl_q          <= '0;
      addr_q         <= '0;
      leaf_q         <= '0;
      wdata_q        <= '0;
      rw_q           <= 1'b0;
      read_val_q     <= '0;
      output_ready_q <= 1'b0;
      for (int b = 0; b < NB; b++)
        for (int z = 0; z < Z; z++) tree_q[b][z] <= '0;
      for (int s = 0; s < S; s++) stash_q[s] <= '0;
`ifdef ORAM_REMAP_EN
      for (int i = 0; i < NL; i++) posmap_q[i] <= D'(i);
`endif
    end else begin
      state_q        <= state_d;
      lvl_q          <= lvl_d;
      addr_q         <= addr_d;
      leaf_q         <= leaf_d;
      wdata_q        <= wdata_d;
      rw_q           <= rw_d;
      read_val_q     <= read_val_d;
      output_ready_q <= (state_q == DONE);
      tree_q         <= tree_d;
      stash_q        <= stash_d;
`ifdef ORAM_REMAP_EN
      posmap_q       <= posmap_d;
`endif
    end
  end

  assign read_val     = read_val_q;
  assign output_ready = output_ready_q;

endmodule

// File: tb/tb_oram.sv
// tb_oram -- self-checking bench for the Path-ORAM controller. A plain
// array of block values (plus a written flag) is the reference: every
// access must return the value last written to that block, or zero.
module tb_oram;
  import oram_pkg::*;

  localparam int LAT = 2 * D + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [D-1:0]  block_num = '0;
  logic [DW-1:0] write_val = '0;
  logic          rw_indicator = 1'b0;
  logic          input_ready = 1'b0;
  logic [DW-1:0] read_val;
  logic          output_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_mem     [NL];
  logic          ref_written [NL];

  oram dut (
    .clk          (clk),
    .rst          (rst),
    .block_num    (block_num),
    .write_val    (write_val),
    .rw_indicator (rw_indicator),
    .input_ready  (input_ready),
    .read_val     (read_val),
    .output_ready (output_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_expect(input logic [D-1:0] blk);
    return ref_written[blk] ? ref_mem[blk] : '0;
  endfunction

  task automatic ref_apply(input logic rw, input logic [D-1:0] blk,
                           input logic [DW-1:0] wv);
    if (rw) begin
      ref_mem[blk]     = wv;
      ref_written[blk] = 1'b1;
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NL; i++) begin
      ref_mem[i]     = '0;
      ref_written[i] = 1'b0;
    end
  endtask

  // Waits up to 40 edges for the completion pulse; lat stays 0 on timeout.
  task automatic wait_done(output int lat, output logic [DW-1:0] rv);
    lat = 0;
    rv  = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (output_ready) begin
        lat = n;
        rv  = read_val;
        break;
      end
    end
  endtask

  // One complete access with a single-cycle request, checked against the model.
  task automatic access(input string tag, input logic rw,
                        input logic [D-1:0] blk, input logic [DW-1:0] wv);
    int            lat;
    logic [DW-1:0] rv;
    logic [DW-1:0] exp;
    exp = ref_expect(blk);
    @(negedge clk);
    rw_indicator = rw;
    block_num    = blk;
    write_val    = wv;
    input_ready  = 1'b1;
    @(posedge clk); #1;
    input_ready  = 1'b0;
    wait_done(lat, rv);
    check({tag, "_lat"}, DW'(lat), DW'(LAT));
    check({tag, "_rv"}, rv, exp);
    ref_apply(rw, blk, wv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    input_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read_val", read_val, '0);
    check("reset_output_ready", DW'(output_ready), '0);
    ref_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  int unsigned stash_occ;
  int unsigned n_written;

  initial begin
    int            lat;
    logic [DW-1:0] rv;
    logic          saw_pulse;

    ref_clear();
    do_reset();

    // Write then read back a single block; latency is checked on each.
    access("w1", 1'b1, 3'd1, 32'h2);
    access("r1", 1'b0, 3'd1, 32'h0);

    // A never-written block reads zero.
    do_reset();
    access("r5_fresh", 1'b0, 3'd5, 32'h0);

    // Fill every block, then read every block.
    for (int i = 0; i < NL; i++) access("fill_w", 1'b1, D'(i), DW'(32'h10 + i));
    for (int i = 0; i < NL; i++) access("fill_r", 1'b0, D'(i), 32'h0);

    // Back-to-back writes with input_ready held high; the second request's
    // inputs change after the first accept and must be sampled at its own.
    do_reset();
    @(negedge clk);
    rw_indicator = 1'b1;
    block_num    = 3'd3;
    write_val    = 32'hA;
    input_ready  = 1'b1;
    @(posedge clk); #1;
    write_val    = 32'hB;
    wait_done(lat, rv);
    check("b2b_first_lat", DW'(lat), DW'(LAT));
    check("b2b_first_rv", rv, '0);
    @(posedge clk); #1;             // second accept edge
    input_ready = 1'b0;
    check("b2b_pulse_width", DW'(output_ready), '0);
    wait_done(lat, rv);
    check("b2b_second_lat", DW'(lat), DW'(LAT));
    check("b2b_second_rv", rv, 32'hA);
    ref_apply(1'b1, 3'd3, 32'hB);
    access("b2b_read", 1'b0, 3'd3, 32'h0);

    // Reset in the middle of READ_PATH aborts and erases everything.
    access("pre_abort_w", 1'b1, 3'd4, 32'h44);
    @(negedge clk);
    rw_indicator = 1'b1;
    block_num    = 3'd2;
    write_val    = 32'h55;
    input_ready  = 1'b1;
    @(posedge clk); #1;
    input_ready  = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_read_val", read_val, '0);
    saw_pulse = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_pulse |= output_ready;
    end
    @(negedge clk);
    rst = 1'b1;
    ref_clear();
    repeat (15) begin
      @(posedge clk); #1;
      saw_pulse |= output_ready;
    end
    check("abort_no_pulse", DW'(saw_pulse), '0);
    access("abort_r4", 1'b0, 3'd4, 32'h0);
    access("abort_r2", 1'b0, 3'd2, 32'h0);

    // Random accesses against the model; the stash may never hold more
    // blocks than exist.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      access("rand", 1'($urandom_range(0, 1)), D'($urandom_range(0, NL - 1)),
             DW'($urandom));
      stash_occ = 0;
      n_written = 0;
      for (int s = 0; s < S; s++) stash_occ += dut.stash_q[s].valid ? 1 : 0;
      for (int i = 0; i < NL; i++) n_written += ref_written[i] ? 1 : 0;
      check("stash_occ", DW'(stash_occ <= n_written), DW'(1));
    end
    for (int i = 0; i < NL; i++) access("final_r", 1'b0, D'(i), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
